// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus one fix-up cycle.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        div0_q;
    logic [31:0] b_q;
    logic [64:0] acc_q;
    logic [31:0] out_q;
    logic        busy_q;
    logic        done_q;

    // Operand conditioning at acceptance
    logic        sgn1, sgn2, neg1, neg2, neg_d;
    logic [31:0] abs1, abs2;

    always_comb begin
        sgn1 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
        sgn2 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        neg1 = sgn1 & in1[31];
        neg2 = sgn2 & in2[31];
        abs1 = neg1 ? (~in1 + 32'd1) : in1;
        abs2 = neg2 ? (~in2 + 32'd1) : in2;
        // REM takes the dividend's sign; every other op takes the product/quotient sign
        neg_d = (op == OP_REM) ? neg1 : (neg1 ^ neg2);
    end

    // One iteration step for each datapath
    logic [32:0] mul_sum;
    logic [64:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [64:0] div_next;

    always_comb begin
        mul_sum  = acc_q[64:32] + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next = {1'b0, mul_sum, acc_q[31:1]};
        rem_sh   = {acc_q[63:32], acc_q[31]};
        trial    = rem_sh - {1'b0, b_q};
        if (!trial[32]) begin
            div_next = {1'b0, trial[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {1'b0, rem_sh[31:0], acc_q[30:0], 1'b0};
        end
    end

    // Fix-up of sign and special cases
    logic [63:0] prod_c;
    logic [31:0] quot_c;
    logic [31:0] rem_c;
    logic [31:0] res_d;

    always_comb begin
        prod_c = neg_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
        quot_c = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_c  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        // Divide by zero forces all-ones quotient regardless of dividend sign
        if (div0_q) begin
            quot_c = 32'hFFFF_FFFF;
        end
        case (op_q)
            OP_MUL:                       res_d = prod_c[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_c[63:32];
            OP_DIV, OP_DIVU:              res_d = quot_c;
            OP_REM, OP_REMU:              res_d = rem_c;
            default:                      res_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            b_q     <= 32'd0;
            acc_q   <= 65'd0;
            out_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    // A start held through DONE is taken on the edge that leaves DONE
                    if (start) begin
                        state_q <= S_CALC;
                        cnt_q   <= 5'd0;
                        op_q    <= op;
                        neg_q   <= neg_d;
                        div0_q  <= (in2 == 32'd0);
                        b_q     <= op[2] ? abs2 : abs1;
                        acc_q   <= {33'd0, op[2] ? abs1 : abs2};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    out_q   <= res_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (o)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'(sa / sb);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
    endtask

    // Called at #1 after the accepting edge; returns edges elapsed until done is seen
    task automatic wait_done(input int pulse_at, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            start = (lat == pulse_at);
            op    = 3'($urandom);
            in1   = $urandom;
            in2   = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
        int   lat;
        logic bok;
        present(o, a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(pulse_at, lat, bok);
        chk({tag, "_lat"}, 32'(lat), 32'd33);
        chk({tag, "_busywin"}, {31'd0, bok}, 32'd1);
        chk({tag, "_busydone"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out"}, out, exp);
        @(posedge clk);
        #1;
        chk({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic        saw_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        in1   = 32'd0;
        in2   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul7x6",  3'd0, 32'd7, 32'd6, 32'd42, -1);
        run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, -1);
        run_op("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("mul_m1",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, -1);
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1);
        run_op("divu_big",  3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, -1);
        run_op("remu_big",  3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, -1);
        run_op("div_by0",   3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, -1);
        run_op("divu_by0",  3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, -1);
        run_op("rem_by0",   3'd6, 32'h1234, 32'd0, 32'h1234, -1);
        run_op("div_negby0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, -1);
        run_op("rem_negby0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, -1);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1);

        run_op("ignore_e5", 3'd0, 32'd1000, 32'd77, 32'd77000, 4);

        // start held through DONE: the second op is taken on the edge leaving DONE
        present(3'd0, 32'd1234, 32'd5678);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(-1, lat, bok);
        chk("chain1_lat", 32'(lat), 32'd33);
        chk("chain1_out", out, 32'd7006652);
        present(3'd5, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        chk("chain2_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(-1, lat, bok);
        chk("chain2_lat", 32'(lat), 32'd33);
        chk("chain2_busywin", {31'd0, bok}, 32'd1);
        chk("chain2_out", out, 32'd333);
        @(posedge clk);
        #1;

        // Reset during an in-flight divide
        present(3'd4, 32'd999, 32'd7);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_out",  out, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_nodone", {31'd0, saw_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = 32'($urandom_range(0, 100));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_model(ro, ra, rb), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
